// File: rtl/ps2_scan_if.sv
// ps2_scan_if: scan-code byte input and decoded key-event outputs of ps2_scan_decoder.
interface ps2_scan_if #(
   parameter int CNT_W = 8
);
   logic [7:0] code;
   logic code_valid;
   logic event_valid;
   logic event_break;
   logic [7:0] key_code;
   logic key_ext;
   logic [7:0] ascii;
   logic key_down;
   logic [CNT_W-1:0] press_count;
   modport master (
      output code, code_valid,
      input event_valid, event_break, key_code, key_ext, ascii, key_down, press_count
   );
   modport slave (
      input code, code_valid,
      output event_valid, event_break, key_code, key_ext, ascii, key_down, press_count
   );
endinterface

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: set-2 scan-code bytes to make/break events, held key, ASCII and press count.
// Define SHIFT_TRACK_EN to track L/R shift (12/59) and produce uppercase letters.
module ps2_scan_decoder #(
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic resetn,
   ps2_scan_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXTBRK = 2'd3;
   logic [1:0] state, nxt;
   logic [31:0] tcnt;
   logic nonkey, take, ext_now, is_brk, fin_make, fin_brk, shift_key, upper, rpt, hit;
   logic [7:0] lc, asc;
   always_comb begin
      nonkey = bus.code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
      take = bus.code_valid && !nonkey;
      ext_now = state == EXT || state == EXTBRK;
      is_brk = state == BRK || state == EXTBRK;
      fin_brk = take && is_brk;
      fin_make = take && !is_brk && bus.code != 8'hE0 && bus.code != 8'hF0;
      nxt = !take ? state : is_brk ? IDLE : bus.code == 8'hF0 ? (ext_now ? EXTBRK : BRK) :
            bus.code == 8'hE0 ? EXT : IDLE;
      hit = {ext_now, bus.code} == {bus.key_ext, bus.key_code};
      rpt = bus.key_down && hit;
      asc = ext_now ? 8'h00 : (upper && lc >= 8'h61 && lc <= 8'h7A) ? lc - 8'h20 : lc;
   end
   always_comb begin
      lc = 8'h00;
      case (bus.code)
         8'h1C: lc = "a"; 8'h32: lc = "b"; 8'h21: lc = "c"; 8'h23: lc = "d";
         8'h24: lc = "e"; 8'h2B: lc = "f"; 8'h34: lc = "g"; 8'h33: lc = "h";
         8'h43: lc = "i"; 8'h3B: lc = "j"; 8'h42: lc = "k"; 8'h4B: lc = "l";
         8'h3A: lc = "m"; 8'h31: lc = "n"; 8'h44: lc = "o"; 8'h4D: lc = "p";
         8'h15: lc = "q"; 8'h2D: lc = "r"; 8'h1B: lc = "s"; 8'h2C: lc = "t";
         8'h3C: lc = "u"; 8'h2A: lc = "v"; 8'h1D: lc = "w"; 8'h22: lc = "x";
         8'h35: lc = "y"; 8'h1A: lc = "z";
         8'h45: lc = "0"; 8'h16: lc = "1"; 8'h1E: lc = "2"; 8'h26: lc = "3";
         8'h25: lc = "4"; 8'h2E: lc = "5"; 8'h36: lc = "6"; 8'h3D: lc = "7";
         8'h3E: lc = "8"; 8'h46: lc = "9";
         8'h29: lc = 8'h20; 8'h5A: lc = 8'h0D;
         default: lc = 8'h00;
      endcase
   end
`ifdef SHIFT_TRACK_EN
   logic shift_l, shift_r;
   assign shift_key = !ext_now && (bus.code == 8'h12 || bus.code == 8'h59);
   assign upper = shift_l | shift_r;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         shift_l <= 1'b0;
         shift_r <= 1'b0;
      end else if ((fin_make || fin_brk) && shift_key) begin
         if (bus.code == 8'h12) shift_l <= fin_make;
         else shift_r <= fin_make;
      end
   end
`else
   assign shift_key = 1'b0;
   assign upper = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         tcnt <= '0;
         bus.event_valid <= 1'b0;
         bus.event_break <= 1'b0;
         bus.key_code <= '0;
         bus.key_ext <= 1'b0;
         bus.ascii <= '0;
         bus.key_down <= 1'b0;
         bus.press_count <= '0;
      end else begin
         bus.event_valid <= 1'b0;
         state <= nxt;
         if ((fin_make || fin_brk) && !shift_key) begin
            bus.event_valid <= 1'b1;
            bus.event_break <= fin_brk;
         end
         if (fin_make && !shift_key && !rpt) begin
            bus.key_code <= bus.code;
            bus.key_ext <= ext_now;
            bus.ascii <= asc;
            bus.key_down <= 1'b1;
            bus.press_count <= bus.press_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (fin_brk && !shift_key && hit) bus.key_down <= 1'b0;
         // an abandoned prefix returns to IDLE silently; code_valid never coincides with it
         if (bus.code_valid || state == IDLE) tcnt <= '0;
         else if (TIMEOUT_CYCLES != 0 && tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            tcnt <= '0;
         end else tcnt <= tcnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed plus random byte streams checked cycle by cycle
// against a prefix-flag keyboard model.
module tb_ps2_scan_decoder;
   localparam int T = 20;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int checks = 0, errors = 0;
   ps2_scan_if #(.CNT_W(8)) bus ();
   ps2_scan_decoder #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
   always #5 clk = ~clk;

   logic [7:0] amap [logic [7:0]];
   logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] dcodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0] pool [14] = '{8'h1C, 8'h32, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'hFA,
      8'h12, 8'h59, 8'h45, 8'h5A, 8'h29};

   bit pe, pb, sl, sr, m_ev, m_brk, m_ext, m_down;
   int idle_n;
   logic [7:0] m_code, m_asc, m_count;

   task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_ascii(input logic [7:0] b, input bit ext);
      logic [7:0] a = (!ext && amap.exists(b)) ? amap[b] : 8'h00;
      return ((sl || sr) && a >= "a" && a <= "z") ? a - 8'h20 : a;
   endfunction

   function automatic bit is_shift(input logic [7:0] b, input bit ext);
`ifdef SHIFT_TRACK_EN
      return !ext && (b == 8'h12 || b == 8'h59);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      {pe, pb, sl, sr, m_ev, m_brk, m_ext, m_down} = '0;
      idle_n = 0;
      m_code = 0; m_asc = 0; m_count = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] b);
      bit ext = pe;
      bit same;
      m_ev = 0;
      if (!v) begin
         if (pe || pb) begin
            idle_n++;
            if (idle_n >= T) begin pe = 0; pb = 0; idle_n = 0; end
         end
         return;
      end
      idle_n = 0;
      if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) return;
      same = (ext == m_ext) && (b == m_code);
      if (pb) begin
         pe = 0; pb = 0;
         if (is_shift(b, ext)) begin
            if (b == 8'h12) sl = 0; else sr = 0;
         end else begin
            m_ev = 1; m_brk = 1;
            if (same) m_down = 0;
         end
      end else if (b == 8'hF0) pb = 1;
      else if (b == 8'hE0) pe = 1;
      else begin
         pe = 0;
         if (is_shift(b, ext)) begin
            if (b == 8'h12) sl = 1; else sr = 1;
         end else begin
            m_ev = 1; m_brk = 0;
            if (!(m_down && same)) begin
               m_code = b; m_ext = ext; m_asc = ref_ascii(b, ext); m_down = 1; m_count++;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk1({tag, ".event_valid"}, bus.event_valid, m_ev);
      if (m_ev) chk1({tag, ".event_break"}, bus.event_break, m_brk);
      chk8({tag, ".key_code"}, bus.key_code, m_code);
      chk1({tag, ".key_ext"}, bus.key_ext, m_ext);
      chk8({tag, ".ascii"}, bus.ascii, m_asc);
      chk1({tag, ".key_down"}, bus.key_down, m_down);
      chk8({tag, ".press_count"}, bus.press_count, m_count);
   endtask

   task automatic step(input bit v, input logic [7:0] b, input string tag);
      @(negedge clk);
      bus.code_valid = v;
      bus.code = b;
      model_step(v, b);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic send(input logic [7:0] b, input string tag);
      step(1'b1, b, tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      resetn = 0;
      bus.code_valid = 1;
      bus.code = 8'h1C;
      model_reset();
      @(posedge clk);
      #1;
      check_all(tag);
      @(negedge clk);
      resetn = 1;
      bus.code_valid = 0;
   endtask

   initial begin
      bus.code = 0;
      bus.code_valid = 0;
      for (int i = 0; i < 26; i++) amap[lcodes[i]] = 8'h61 + 8'(i);
      for (int i = 0; i < 10; i++) amap[dcodes[i]] = 8'h30 + 8'(i);
      amap[8'h29] = 8'h20;
      amap[8'h5A] = 8'h0D;
      do_reset("reset");
      send(8'h1C, "tp1");
      chk8("tp1_ascii", bus.ascii, 8'h61);
      idle(1, "tp1_pulse");
      send(8'h1C, "rep1"); send(8'h1C, "rep2"); send(8'hF0, "rep_f0"); send(8'h1C, "rep_brk");
      chk1("rep_down", bus.key_down, 1'b0);
      chk8("rep_count", bus.press_count, 8'h01);
      do_reset("reset2");
      send(8'hE0, "ext"); send(8'h75, "ext_mk");
      chk1("ext_flag", bus.key_ext, 1'b1);
      send(8'hE0, "ext2"); send(8'hF0, "ext_f0"); send(8'h75, "ext_brk");
      do_reset("reset3");
      send(8'h1C, "two_a"); send(8'h32, "two_b"); send(8'hF0, "two_f0"); send(8'h1C, "two_brk");
      chk1("two_down", bus.key_down, 1'b1);
      chk8("two_count", bus.press_count, 8'h02);
      send(8'hF0, "to_f0"); idle(T, "to_wait"); send(8'h1C, "to_make");
      chk1("to_make_brk", bus.event_break, 1'b0);
      send(8'hF0, "nto_f0"); idle(T - 1, "nto_wait"); send(8'h1C, "nto_brk");
      chk1("nto_brk_flag", bus.event_break, 1'b1);
      send(8'hE0, "nk_e0"); send(8'hAA, "nk_aa"); send(8'hF0, "nk_f0"); send(8'hFA, "nk_fa");
      send(8'h1C, "nk_brk");
      send(8'hF0, "mid_f0");
      do_reset("mid_reset");
      send(8'h1C, "post_reset");
`ifdef SHIFT_TRACK_EN
      do_reset("reset_sh");
      send(8'h12, "sh_mk"); send(8'h1C, "sh_a");
      chk8("sh_upper", bus.ascii, 8'h41);
      send(8'hF0, "sh_f0"); send(8'h12, "sh_brk"); send(8'h32, "sh_b");
      chk8("sh_lower", bus.ascii, 8'h62);
      chk8("sh_count", bus.press_count, 8'h02);
`endif
      do_reset("reset_wrap");
      for (int i = 0; i < 260; i++) send(i % 2 ? 8'h32 : 8'h1C, "wrap");
      chk8("wrap_count", bus.press_count, 8'h04);
      do_reset("reset_rand");
      for (int i = 0; i < 1500; i++) begin
         int r = int'($urandom_range(0, 39));
         if (r == 0) idle(int'($urandom_range(T - 3, T + 3)), "rand_idle");
         else if (r < 14) step(1'b0, 8'(($urandom)), "rand_nv");
         else if (r < 19) send(8'($urandom), "rand_any");
         else send(pool[$urandom_range(0, 13)], "rand");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
